// File: rtl/nes_button_events.sv
// Turns raw controller samples into debounced held state plus press, release and
// auto-repeat pulses. Every counter advances on sample strobes, never on bare clocks.
module nes_button_events #(
  parameter int         DEBOUNCE_SAMPLES = 3,
  parameter int         REPEAT_DELAY     = 30,
  parameter int         REPEAT_RATE      = 6,
  parameter logic [7:0] REPEAT_MASK      = 8'hF0
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_buttons,
  output logic [7:0] o_held,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic [7:0] o_repeat,
  output logic       o_event_valid
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);
  localparam int DW   = (DEBOUNCE_SAMPLES <= 1) ? 1 : $clog2(DEBOUNCE_SAMPLES);

  localparam logic [DW-1:0] DLIM   = DW'(DEBOUNCE_SAMPLES - 1);
  localparam logic [RW-1:0] RDELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RRATE  = RW'(REPEAT_RATE);

  logic [7:0] held_reg;
  logic [7:0] pressed_reg;
  logic [7:0] released_reg;
  logic [7:0] repeat_reg;
  logic       event_valid_reg;

  logic [7:0] held_next;
  logic [7:0] pressed_next;
  logic [7:0] released_next;
  logic [7:0] repeat_next;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      logic [DW-1:0] dcnt_reg;
      logic [DW-1:0] dcnt_next;
      logic          differ;
      logic          flip;

      assign differ = i_buttons[gi] ^ held_reg[gi];
      assign flip   = differ && (dcnt_reg == DLIM);

      // Any agreeing sample clears the count, so only unbroken runs can flip the state.
      always_comb begin
        dcnt_next = dcnt_reg;
        if (!differ || flip) begin
          dcnt_next = '0;
        end else begin
          dcnt_next = dcnt_reg + DW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (i_rst) begin
          dcnt_reg <= '0;
        end else if (i_valid) begin
          dcnt_reg <= dcnt_next;
        end
      end

      assign held_next[gi]     = held_reg[gi] ^ flip;
      assign pressed_next[gi]  = flip & i_buttons[gi];
      assign released_next[gi] = flip & ~i_buttons[gi];

      if (REPEAT_MASK[gi] && (REPEAT_DELAY > 0)) begin : g_rep
        logic [RW-1:0] rcnt_reg;
        logic [RW-1:0] rcnt_next;
        logic [RW-1:0] rcnt_inc;
        logic [RW-1:0] rcnt_lim;
        logic          phase_rate_reg;
        logic          phase_rate_next;
        logic          rep_next;

        assign rcnt_inc = rcnt_reg + RW'(1);
        assign rcnt_lim = phase_rate_reg ? RRATE : RDELAY;

        // A flipping sample only restarts the delay phase, so a press never repeats at once.
        always_comb begin
          rcnt_next       = rcnt_reg;
          phase_rate_next = phase_rate_reg;
          rep_next        = 1'b0;
          if (flip) begin
            rcnt_next       = '0;
            phase_rate_next = 1'b0;
          end else if (held_reg[gi]) begin
            if (rcnt_inc == rcnt_lim) begin
              rep_next        = 1'b1;
              rcnt_next       = '0;
              phase_rate_next = 1'b1;
            end else begin
              rcnt_next = rcnt_inc;
            end
          end
        end

        always_ff @(posedge clk) begin
          if (i_rst) begin
            rcnt_reg       <= '0;
            phase_rate_reg <= 1'b0;
          end else if (i_valid) begin
            rcnt_reg       <= rcnt_next;
            phase_rate_reg <= phase_rate_next;
          end
        end

        assign repeat_next[gi] = rep_next;
      end else begin : g_norep
        assign repeat_next[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_rst) begin
      held_reg        <= '0;
      pressed_reg     <= '0;
      released_reg    <= '0;
      repeat_reg      <= '0;
      event_valid_reg <= 1'b0;
    end else begin
      if (i_valid) begin
        held_reg <= held_next;
      end
      pressed_reg     <= i_valid ? pressed_next  : '0;
      released_reg    <= i_valid ? released_next : '0;
      repeat_reg      <= i_valid ? repeat_next   : '0;
      event_valid_reg <= i_valid & (|(pressed_next | released_next | repeat_next));
    end
  end

  assign o_held        = held_reg;
  assign o_pressed     = pressed_reg;
  assign o_released    = released_reg;
  assign o_repeat      = repeat_reg;
  assign o_event_valid = event_valid_reg;

endmodule

// File: tb/tb_nes_button_events.sv
// Directed bench: one DUT with short debounce/repeat settings, a second with
// single-sample debounce and auto-repeat disabled, both fed the same samples.
module tb_nes_button_events;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [7:0] buttons;

  logic [7:0] held1, pressed1, released1, repeat1;
  logic       ev1;
  logic [7:0] held2, pressed2, released2, repeat2;
  logic       ev2;

  int checks    = 0;
  int errors    = 0;
  int rep2_seen = 0;
  bit mon_en    = 1'b0;

  nes_button_events #(
    .DEBOUNCE_SAMPLES(3),
    .REPEAT_DELAY    (4),
    .REPEAT_RATE     (2),
    .REPEAT_MASK     (8'hF0)
  ) dut1 (
    .clk          (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_buttons    (buttons),
    .o_held       (held1),
    .o_pressed    (pressed1),
    .o_released   (released1),
    .o_repeat     (repeat1),
    .o_event_valid(ev1)
  );

  nes_button_events #(
    .DEBOUNCE_SAMPLES(1),
    .REPEAT_DELAY    (0),
    .REPEAT_RATE     (2),
    .REPEAT_MASK     (8'hF0)
  ) dut2 (
    .clk          (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_buttons    (buttons),
    .o_held       (held2),
    .o_pressed    (pressed2),
    .o_released   (released2),
    .o_repeat     (repeat2),
    .o_event_valid(ev2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && (repeat2 !== 8'h00)) rep2_seen++;
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one sample; returns at the negedge where its registered results are visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid   = 1'b1;
    buttons = b;
    @(negedge clk);
    valid   = 1'b0;
    buttons = 8'($urandom);
    $display("t=%0t sample=%02h held=%02h pressed=%02h released=%02h repeat=%02h ev=%0b | held2=%02h pressed2=%02h",
             $time, b, held1, pressed1, released1, repeat1, ev1, held2, pressed2);
  endtask

  // Pulses must be gone one cycle later; then pad out to a 10-cycle strobe spacing.
  task automatic settle();
    @(negedge clk);
    chk8("pulse_clear1", pressed1 | released1 | repeat1 | {7'b0, ev1}, 8'h00);
    chk8("pulse_clear2", pressed2 | released2 | repeat2 | {7'b0, ev2}, 8'h00);
    repeat (7) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] b, input logic [7:0] ep, input logic [7:0] er,
                        input logic [7:0] erp, input logic [7:0] eh);
    send(b);
    chk8("pressed", pressed1, ep);
    chk8("released", released1, er);
    chk8("repeat", repeat1, erp);
    chk8("held", held1, eh);
    chk8("event_valid", {7'b0, ev1}, {7'b0, |(ep | er | erp)});
    settle();
  endtask

  task automatic strobe2(input logic [7:0] b, input logic [7:0] ep2, input logic [7:0] eh2,
                         input logic [7:0] ep1, input logic [7:0] eh1);
    send(b);
    chk8("fast_pressed", pressed2, ep2);
    chk8("fast_held", held2, eh2);
    chk8("fast_repeat", repeat2, 8'h00);
    chk8("fast_event_valid", {7'b0, ev2}, {7'b0, |ep2});
    chk8("slow_pressed", pressed1, ep1);
    chk8("slow_held", held1, eh1);
    settle();
  endtask

  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    buttons = 8'h00;

    // Reset and idle
    do_reset(2);
    mon_en = 1'b1;
    chk8("rst_held", held1, 8'h00);
    chk8("rst_pulses", pressed1 | released1 | repeat1 | {7'b0, ev1}, 8'h00);
    chk8("rst_fast", held2 | pressed2 | released2 | repeat2 | {7'b0, ev2}, 8'h00);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk8("idle_quiet", held1 | pressed1 | released1 | repeat1 | {7'b0, ev1}, 8'h00);
    end

    // Basic press and release of A
    strobe(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
    strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    strobe(8'h00, 8'h00, 8'h01, 8'h00, 8'h00);

    // Glitch on B clears the run; three unbroken samples then press
    strobe(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h02, 8'h02, 8'h00, 8'h00, 8'h02);
    strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h02);
    strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h02);
    strobe(8'h00, 8'h00, 8'h02, 8'h00, 8'h00);

    // Hold Up: press on sample 3, repeats after samples 7, 9, 11, 13
    for (int k = 1; k <= 14; k++) begin
      strobe(8'h10,
             (k == 3) ? 8'h10 : 8'h00,
             8'h00,
             (k >= 7 && (k % 2) == 1) ? 8'h10 : 8'h00,
             (k >= 3) ? 8'h10 : 8'h00);
    end

    // Up -> Down. Up is still held during the first two samples, so its rate
    // count keeps running and fires once more on the first changed sample.
    strobe(8'h20, 8'h00, 8'h00, 8'h10, 8'h10);
    strobe(8'h20, 8'h00, 8'h00, 8'h00, 8'h10);
    strobe(8'h20, 8'h20, 8'h10, 8'h00, 8'h20);
    strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h20);
    strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h20);
    strobe(8'h00, 8'h00, 8'h20, 8'h00, 8'h00);

    // Hold A: masked, never repeats
    for (int k = 1; k <= 14; k++) begin
      strobe(8'h01, (k == 3) ? 8'h01 : 8'h00, 8'h00, 8'h00, (k >= 3) ? 8'h01 : 8'h00);
    end
    strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    strobe(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    strobe(8'h00, 8'h00, 8'h01, 8'h00, 8'h00);

    // Reset mid-debounce discards the partial count
    strobe(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset(1);
    strobe(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    strobe(8'h80, 8'h80, 8'h00, 8'h00, 8'h80);

    // Right held through reset; fast instance follows at once, slow re-presses after 3
    do_reset(1);
    chk8("rst2_held", held1 | held2, 8'h00);
    strobe2(8'h80, 8'h80, 8'h80, 8'h00, 8'h00);
    strobe2(8'h80, 8'h00, 8'h80, 8'h00, 8'h00);
    strobe2(8'h80, 8'h00, 8'h80, 8'h80, 8'h80);
    for (int k = 0; k < 6; k++) begin
      strobe2(8'h80, 8'h00, 8'h80, 8'h00, 8'h80);
    end
    send(8'h00);
    chk8("fast_released", released2, 8'h80);
    chk8("fast_held_off", held2, 8'h00);
    settle();

    checks++;
    assert (rep2_seen == 0)
    else begin
      errors++;
      $error("FAIL fast_repeat_never observed=%0d expected=0", rep2_seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
